// File: rtl/cordic_rotation_iter_pkg.sv
// Shared constants and FSM encoding for the folded rotation-mode CORDIC engine.
// Angles are signed binary fractions of pi: 0x8000 = -pi, 0x4000 = +pi/2.
package cordic_rotation_iter_pkg;

    localparam int PHASE_WIDTH     = 16;
    localparam int ITERATION_WIDTH = 4;

    localparam logic signed [PHASE_WIDTH-1:0] PHASE_HALF_PI     = 16'sh4000;
    localparam logic signed [PHASE_WIDTH-1:0] PHASE_NEG_HALF_PI = 16'shC000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_rotation_iter_atan_rom.sv
// Combinational arctangent table: entry i = round(atan(2^-i) / pi * 32768).
// Shared with the vectoring-mode pipeline so both use identical micro-angles.
module cordic_atan_rom
    import cordic_rotation_iter_pkg::*;
(
    input  logic        [ITERATION_WIDTH-1:0] idx,
    output logic signed [PHASE_WIDTH-1:0]     atan
);

    always_comb begin
        atan = '0;
        case (idx)
            4'd0:  atan = 16'sd8192;
            4'd1:  atan = 16'sd4836;
            4'd2:  atan = 16'sd2555;
            4'd3:  atan = 16'sd1297;
            4'd4:  atan = 16'sd651;
            4'd5:  atan = 16'sd326;
            4'd6:  atan = 16'sd163;
            4'd7:  atan = 16'sd81;
            4'd8:  atan = 16'sd41;
            4'd9:  atan = 16'sd20;
            4'd10: atan = 16'sd10;
            4'd11: atan = 16'sd5;
            4'd12: atan = 16'sd3;
            4'd13: atan = 16'sd1;
            4'd14: atan = 16'sd1;
            4'd15: atan = 16'sd0;
            default: atan = '0;
        endcase
    end

endmodule

// File: rtl/cordic_rotation_iter.sv
// Folded rotation-mode CORDIC: one shared add/sub datapath runs ITERATIONS
// micro-rotations per transaction. Outputs carry the uncompensated gain K ~ 1.6468.
module cordic_rotation_iter
    import cordic_rotation_iter_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ITERATIONS = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WORD_WIDTH-1:0]  x_in,
    input  logic signed [WORD_WIDTH-1:0]  y_in,
    input  logic signed [PHASE_WIDTH-1:0] z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WORD_WIDTH+1:0]  x_out,
    output logic signed [WORD_WIDTH+1:0]  y_out,
    output logic signed [PHASE_WIDTH-1:0] z_out
);

    localparam int XW = WORD_WIDTH + 2;
    localparam logic [ITERATION_WIDTH-1:0] LAST_ITER = ITERATION_WIDTH'(ITERATIONS - 1);

    state_t                       state;
    logic [ITERATION_WIDTH-1:0]   i_r;
    logic signed [XW-1:0]         x_r, y_r;
    logic signed [PHASE_WIDTH-1:0] z_r;

    logic signed [PHASE_WIDTH-1:0] atan_i;
    logic signed [XW-1:0]          x_sh, y_sh, x_nx, y_nx;
    logic signed [PHASE_WIDTH-1:0] z_nx;
    logic                          d_pos;

    cordic_atan_rom u_rom (
        .idx  (i_r),
        .atan (atan_i)
    );

    // z == 0 rotates in the positive direction
    assign d_pos = ~z_r[PHASE_WIDTH-1];
    assign x_sh  = x_r >>> i_r;
    assign y_sh  = y_r >>> i_r;
    assign x_nx  = d_pos ? (x_r - y_sh)   : (x_r + y_sh);
    assign y_nx  = d_pos ? (y_r + x_sh)   : (y_r - x_sh);
    assign z_nx  = d_pos ? (z_r - atan_i) : (z_r + atan_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            i_r       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r      <= {{2{x_in[WORD_WIDTH-1]}}, x_in};
                        y_r      <= {{2{y_in[WORD_WIDTH-1]}}, y_in};
                        z_r      <= z_in;
                        in_ready <= 1'b0;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    // fold angles beyond +/-pi/2 into the CORDIC convergence range
                    if (z_r > PHASE_HALF_PI) begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= z_r - PHASE_HALF_PI;
                    end else if (z_r < PHASE_NEG_HALF_PI) begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= z_r + PHASE_HALF_PI;
                    end
                    i_r   <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    i_r <= i_r + 1'b1;
                    if (i_r == LAST_ITER) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign x_out = x_r;
    assign y_out = y_r;
    assign z_out = z_r;

endmodule

// File: tb/tb_cordic_rotation_iter.sv
// Scoreboard bench for cordic_rotation_iter: directed vectors with hand-traced
// bit-exact results; a negedge monitor pops expectations on each output handshake.
module tb_cordic_rotation_iter;

    localparam int WW = 16;
    localparam int IT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid;
    logic signed [WW-1:0] x_in = '0, y_in = '0;
    logic signed [15:0]   z_in = '0;
    logic signed [WW+1:0] x_out, y_out;
    logic signed [15:0]   z_out;

    always #5 clk = ~clk;

    cordic_rotation_iter #(.WORD_WIDTH(WW), .ITERATIONS(IT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    typedef struct {
        int id;
        int x;
        int y;
        int z;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // 0: z=0, 1: pi/4, 2: 3pi/4 (pre-rotate +), 3: -3pi/4 (pre-rotate -),
    // 4: full-scale x=y at pi/4, 5: -pi
    int vx[6] = '{10000, 10000, 10000, 10000, 32767, 10000};
    int vy[6] = '{0, 0, 0, 0, 32767, 0};
    int vz[6] = '{'h0000, 'h2000, 'h6000, 'hA000, 'h2000, 'h8000};
    int ex[6] = '{16468, 11644, -11646, -11642, -15, -16471};
    int ey[6] = '{-5, 11646, 11643, -11647, 76311, 8};
    int ez[6] = '{3, -1, -1, -1, -1, 3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int id, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d", nm, id, act, want);
        end
    endtask

    task automatic send(int k, bit push);
        bit acc;
        exp_t e;
        e.id = k; e.x = ex[k]; e.y = ey[k]; e.z = ez[k];
        if (push) sb.push_back(e);
        x_in = WW'(vx[k]);
        y_in = WW'(vy[k]);
        z_in = 16'(vz[k]);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept[%0d] got=timeout want=in_ready", k);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // monitor: latency on out_valid rise, data on each output handshake
    initial begin
        exp_t e;
        logic ov_q;
        ov_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_valid && in_ready) acc_cyc = cyc;
                if (out_valid && !ov_q) chk("latency", -1, cyc - acc_cyc, IT + 2);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out got=x%0d want=none", int'(x_out));
                    end else begin
                        e = sb.pop_front();
                        chk("x_out", e.id, int'(x_out), e.x);
                        chk("y_out", e.id, int'(y_out), e.y);
                        chk("z_out", e.id, int'(z_out), e.z);
                    end
                end
            end
            ov_q = out_valid & ~rst;
        end
    end

    initial begin
        bit got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", -1, int'(in_ready), 1);
        chk("rst_out_valid", -1, int'(out_valid), 0);
        chk("rst_x_out", -1, int'(x_out), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 6; k++) send(k, 1'b1);
        drain();

        // back-pressure in DONE: outputs hold, in_valid pulses are ignored
        out_ready = 1'b0;
        send(1, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = out_valid;
            if (!got) @(posedge clk);
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL stall_wait got=timeout want=out_valid");
        end
        for (int s = 0; s < 5; s++) begin
            chk("stall_x", s, int'(x_out), ex[1]);
            chk("stall_y", s, int'(y_out), ey[1]);
            chk("stall_z", s, int'(z_out), ez[1]);
            chk("stall_in_ready", s, int'(in_ready), 0);
            chk("stall_out_valid", s, int'(out_valid), 1);
            @(posedge clk);
            #1;
            x_in = 16'sd123;
            z_in = 16'sh1234;
            in_valid = (s < 4) && (s % 2 == 0);
            if (s == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", -1, int'(in_ready), 1);
        chk("release_out_valid", -1, int'(out_valid), 0);
        @(posedge clk);
        #1;
        send(5, 1'b1);
        drain();

        // reset in the middle of ITER (i == 5) aborts without output
        send(0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", -1, int'(in_ready), 1);
        chk("abort_out_valid", -1, int'(out_valid), 0);
        chk("abort_x_out", -1, int'(x_out), 0);
        chk("abort_y_out", -1, int'(y_out), 0);
        chk("abort_z_out", -1, int'(z_out), 0);
        @(posedge clk);
        #1;
        send(3, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
